// File: rtl/prog_loader.sv
// prog_loader: UART boot loader for the instruction memory.
//
// Waits for SYNC_BYTE, then assembles the following bytes big-endian into
// 32-bit words and writes them to consecutive instruction-memory addresses.
// An all-zero word ends the image. An image that fills the whole memory
// without a terminator ends the load with an error. The loader then sends
// a one-byte acknowledge (0x55 ok, 0xEE overflow) and releases the core.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   rx_data       received byte, valid while rx_ready=1
//   rx_ready      one-cycle pulse per received byte
//   tx_busy       UART transmitter busy
//   tx_data       acknowledge byte, driven while acknowledging
//   tx_start      one-cycle transmit request
//   imem_we       instruction-memory write strobe
//   imem_addr     word address of the write
//   imem_wdata    word to write
//   cpu_run       core may fetch and execute
//   word_count    words written this session, terminator included
//   load_err      image overflowed instruction memory (sticky)
//   state         current FSM state, for the LEDs
module prog_loader #(
   parameter int         INST_SIZE = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_ready,
   input  logic                 tx_busy,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   output logic                 imem_we,
   output logic [INST_SIZE-1:0] imem_addr,
   output logic [31:0]          imem_wdata,
   output logic                 cpu_run,
   output logic [INST_SIZE:0]   word_count,
   output logic                 load_err,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ACK  = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

   localparam logic [INST_SIZE-1:0] ADDR_MAX  = '1;
   localparam logic [INST_SIZE:0]   COUNT_MAX = {1'b1, {INST_SIZE{1'b0}}};

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;      // first three bytes of the word being assembled

   logic sync_seen;
   logic last_write;
   logic overflow_write;
   logic byte_accept;

   assign sync_seen = rx_ready && (rx_data == SYNC_BYTE);

   // The write cycle of a word decides whether the session ends: a zero
   // word is the terminator, and any word at the top address leaves no
   // room for another one.
   assign last_write     = imem_we && ((imem_wdata == 32'h0) || (imem_addr == ADDR_MAX));
   assign overflow_write = imem_we && (imem_wdata != 32'h0) && (imem_addr == ADDR_MAX);

   // A byte arriving in the final write cycle belongs to no session.
   assign byte_accept = rx_ready && (state_q == ST_LOAD) && !last_write;

   assign state = state_q;

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the values from before the edge, independent of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      cpu_run  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync_seen) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (last_write) state_d = ST_ACK;
         end
         ST_ACK: begin
            tx_data = load_err ? 8'hEE : 8'h55;
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            cpu_run = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx   <= 2'd0;
         asm_q      <= 24'h0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0;
         word_count <= '0;
         load_err   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync_seen) begin
                  byte_idx   <= 2'd0;
                  imem_addr  <= '0;
                  word_count <= '0;
               end
            end
            ST_LOAD: begin
               // Bookkeeping for the word being written this cycle. The
               // address stops at the top so it can never wrap to 0.
               if (imem_we) begin
                  if (imem_addr != ADDR_MAX)   imem_addr  <= imem_addr + 1'b1;
                  if (word_count != COUNT_MAX) word_count <= word_count + 1'b1;
                  if (overflow_write)          load_err   <= 1'b1;
               end
               // byte_idx wraps 3 -> 0, so the byte landing in the write
               // cycle starts the next word.
               if (byte_accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {asm_q, rx_data};
                  end else begin
                     asm_q <= {asm_q[15:0], rx_data};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader (INST_SIZE=2 so the
// overflow path is reachable). A session model fed with every driven byte
// predicts the write stream, the acknowledge and the state sequence; one
// compare process checks all outputs each cycle, and each scenario ends
// with hand-computed literal expectations.
module tb_prog_loader;

   localparam int         INST     = 2;
   localparam int         ADDR_TOP = (1 << INST) - 1;
   localparam int         CNT_TOP  = 1 << INST;
   localparam logic [7:0] SYNC     = 8'hAA;
   localparam int         NONE     = 32'h7fff_ffff;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready = 1'b0;
   logic              tx_busy = 1'b0;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              imem_we;
   logic [INST-1:0]   imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_run;
   logic [INST:0]     word_count;
   logic              load_err;
   logic [1:0]        state;

   prog_loader #(.INST_SIZE(INST), .SYNC_BYTE(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .word_count (word_count),
      .load_err   (load_err),
      .state      (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- session model ----------------
   typedef struct {
      int          stamp;   // cycle in which imem_we must be high
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          wr_stamps[$];
   int          m_phase;    // 0 waiting for sync, 1 loading, 2 session over
   int          m_nbytes;
   int          m_addr;
   logic [31:0] m_word;
   int          load_from, ack_from, err_from, ack_cyc;
   logic [7:0]  ack_byte;

   // observations of the DUT, for the literal checks
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          tx_pulses;
   int          pulse_cyc;
   logic [7:0]  last_tx;

   task automatic model_reset();
      exp_q.delete();
      wr_stamps.delete();
      obs_addr.delete();
      obs_data.delete();
      m_phase   = 0;
      m_nbytes  = 0;
      m_addr    = 0;
      m_word    = 32'h0;
      load_from = NONE;
      ack_from  = NONE;
      err_from  = NONE;
      ack_cyc   = NONE;
      ack_byte  = 8'h00;
      tx_pulses = 0;
      pulse_cyc = NONE;
      last_tx   = 8'h00;
   endtask

   // Called for a byte presented in cycle cyc.
   task automatic model_byte(input logic [7:0] b);
      wr_t w;
      if (m_phase == 0) begin
         if (b == SYNC) begin
            m_phase   = 1;
            load_from = cyc + 1;
            m_nbytes  = 0;
            m_addr    = 0;
         end
      end else if (m_phase == 1) begin
         m_word = {m_word[23:0], b};
         m_nbytes++;
         if (m_nbytes == 4) begin
            w.stamp = cyc + 1;
            w.addr  = m_addr;
            w.data  = m_word;
            exp_q.push_back(w);
            wr_stamps.push_back(cyc + 1);
            m_nbytes = 0;
            if (m_word == 32'h0) begin
               m_phase  = 2;
               ack_from = cyc + 2;
               ack_byte = 8'h55;
            end else if (m_addr == ADDR_TOP) begin
               m_phase  = 2;
               ack_from = cyc + 2;
               ack_byte = 8'hEE;
               err_from = cyc + 2;
            end else begin
               m_addr++;
            end
         end
      end
   endtask

   function automatic int exp_state(input int c);
      if (ack_cyc != NONE && c > ack_cyc) return 3;
      if (c >= ack_from)  return 2;
      if (c >= load_from) return 1;
      return 0;
   endfunction

   // A write is counted from the cycle after its strobe.
   function automatic int exp_wc(input int c);
      int n = 0;
      foreach (wr_stamps[i]) if (wr_stamps[i] < c) n++;
      return (n > CNT_TOP) ? CNT_TOP : n;
   endfunction

   // ---------------- compare process ----------------
   int   es;
   logic exp_tx;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_state",      state,      0);
         check("rst_tx_data",    tx_data,    0);
         check("rst_tx_start",   tx_start,   0);
         check("rst_imem_we",    imem_we,    0);
         check("rst_imem_addr",  imem_addr,  0);
         check("rst_imem_wdata", imem_wdata, 0);
         check("rst_cpu_run",    cpu_run,    0);
         check("rst_word_count", word_count, 0);
         check("rst_load_err",   load_err,   0);
      end else begin
         es     = exp_state(cyc);
         exp_tx = (es == 2) && !tx_busy;
         check("state",    state,    es);
         check("cpu_run",  cpu_run,  es == 3);
         check("tx_start", tx_start, exp_tx);
         check("tx_data",  tx_data,  (es == 2) ? ack_byte : 8'h00);
         if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
            check("imem_we",    imem_we,    1);
            check("imem_addr",  imem_addr,  exp_q[0].addr);
            check("imem_wdata", imem_wdata, exp_q[0].data);
            void'(exp_q.pop_front());
         end else begin
            check("imem_we_idle", imem_we, 0);
         end
         check("word_count", word_count, exp_wc(cyc));
         check("load_err",   load_err,   cyc >= err_from);
         if (exp_tx) ack_cyc = cyc;
         if (imem_we) begin
            obs_addr.push_back(32'(imem_addr));
            obs_data.push_back(imem_wdata);
         end
         if (tx_start) begin
            tx_pulses++;
            pulse_cyc = cyc;
            last_tx   = tx_data;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_ready = 1'b1;
      model_byte(b);
      tick();
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      repeat (gap) tick();
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic check_wr(input string name, input int idx, input int addr, input logic [31:0] data);
      if (idx < obs_addr.size()) begin
         check({name, "_addr"}, obs_addr[idx], addr);
         check({name, "_data"}, obs_data[idx], data);
      end else begin
         check({name, "_missing"}, obs_addr.size(), idx + 1);
      end
   endtask

   int drop_cyc;

   initial begin
      model_reset();
      repeat (3) tick();

      // Normal load with idle gaps, then sync and data while running.
      do_reset();
      send(SYNC, 1);
      send_word(32'h2008_0005, 2);
      send_word(32'h0000_0000, 1);
      repeat (6) tick();
      check("t1_nwrites", obs_addr.size(), 2);
      check_wr("t1_w0", 0, 0, 32'h2008_0005);
      check_wr("t1_w1", 1, 1, 32'h0000_0000);
      check("t1_word_count", word_count, 2);
      check("t1_ack", last_tx, 8'h55);
      check("t1_pulses", tx_pulses, 1);
      check("t1_cpu_run", cpu_run, 1);
      send(SYNC, 0);
      send_word(32'h0102_0304, 0);
      repeat (3) tick();
      check("t1_run_state", state, 3);
      check("t1_run_nwrites", obs_addr.size(), 2);

      // Noise before sync.
      do_reset();
      send(8'h12, 1);
      send(8'hFF, 1);
      send(SYNC, 0);
      send_word(32'h0, 0);
      repeat (6) tick();
      check("t2_nwrites", obs_addr.size(), 1);
      check_wr("t2_w0", 0, 0, 32'h0);
      check("t2_ack", last_tx, 8'h55);
      check("t2_word_count", word_count, 1);

      // Overflow: four nonzero words fill the memory; later bytes ignored.
      do_reset();
      send(SYNC, 0);
      send_word(32'h0102_0304, 1);
      send_word(32'h0506_0708, 1);
      send_word(32'h090A_0B0C, 1);
      send_word(32'h0D0E_0F10, 1);
      send_word(32'h1122_3344, 0);
      repeat (6) tick();
      check("t3_nwrites", obs_addr.size(), 4);
      check_wr("t3_w0", 0, 0, 32'h0102_0304);
      check_wr("t3_w3", 3, 3, 32'h0D0E_0F10);
      check("t3_load_err", load_err, 1);
      check("t3_ack", last_tx, 8'hEE);
      check("t3_word_count", word_count, 4);
      check("t3_pulses", tx_pulses, 1);

      // Busy transmitter holds the acknowledge back.
      do_reset();
      tx_busy = 1'b1;
      send(SYNC, 0);
      send_word(32'h0, 0);
      repeat (50) tick();
      check("t4_no_pulse_yet", tx_pulses, 0);
      check("t4_state_ack", state, 2);
      tx_busy  = 1'b0;
      drop_cyc = cyc;
      repeat (5) tick();
      check("t4_pulses", tx_pulses, 1);
      check("t4_pulse_cycle", pulse_cyc, drop_cyc);
      check("t4_state_run", state, 3);

      // Reset in the middle of a word.
      do_reset();
      send(SYNC, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      rst = 1'b1;
      model_reset();
      tick();
      check("t5_rst_state", state, 0);
      check("t5_rst_we", imem_we, 0);
      tick();
      rst = 1'b0;
      tick();
      send(SYNC, 1);
      send_word(32'h0, 1);
      repeat (6) tick();
      check("t5_nwrites", obs_addr.size(), 1);
      check_wr("t5_w0", 0, 0, 32'h0);
      check("t5_ack", last_tx, 8'h55);

      // Back-to-back bytes, with the sync value used as data.
      do_reset();
      send(SYNC, 0);
      send_word(32'hAA01_0203, 0);
      send_word(32'h0, 0);
      repeat (6) tick();
      check("t6_nwrites", obs_addr.size(), 2);
      check_wr("t6_w0", 0, 0, 32'hAA01_0203);
      check_wr("t6_w1", 1, 1, 32'h0);
      check("t6_word_count", word_count, 2);
      check("t6_ack", last_tx, 8'h55);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter INST_SIZE, default 8, giving the instruction-memory word-address width (2^INST_SIZE words).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hAA, the byte that opens a load session.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received UART byte, valid while rx_ready=1.
- rx_ready  input  1  one-cycle pulse per received byte.
- tx_busy  input  1  UART transmitter busy.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  one-cycle transmit request.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  INST_SIZE  word address of the write.
- imem_wdata  output  32  word to write.
- cpu_run  output  1  core may fetch and execute.
- word_count  output  INST_SIZE+1  words written this session, terminator included.
- load_err  output  1  image overflowed instruction memory.
- state  output  2  current FSM state, for the LEDs.

Function
REQ-004 SHALL implement the FSM IDLE=0, LOAD=1, ACK=2, RUN=3, driven on the state output.
REQ-005 IDLE: on rx_ready with rx_data==SYNC_BYTE, SHALL enter LOAD and clear the byte index, write address and word_count; SHALL ignore all other bytes.
REQ-006 LOAD: SHALL assemble bytes big-endian: 1st byte to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-007 SHALL treat SYNC_BYTE as ordinary data inside LOAD.
REQ-008 On the 4th byte's rx_ready cycle N, SHALL assert imem_we for exactly cycle N+1, with imem_addr = current write address and imem_wdata = the assembled word.
REQ-009 In cycle N+1, SHALL increment the write address and word_count, and reset the byte index to 0.
REQ-010 An assembled word of 32'h0 is the terminator: SHALL write it like any other word, then enter ACK in cycle N+1.
REQ-011 A nonzero word written at address 2^INST_SIZE-1: SHALL set load_err and enter ACK in cycle N+1; the write address SHALL never wrap to 0.
REQ-012 SHALL accept rx_ready on consecutive cycles without dropping bytes.
REQ-013 ACK: in the first cycle with tx_busy=0, SHALL assert tx_start for one cycle with tx_data = 8'h55 (load_err=0) or 8'hEE (load_err=1), then enter RUN in the next cycle.
REQ-014 ACK: while tx_busy=1, SHALL hold tx_start=0 and wait.
REQ-015 RUN: SHALL hold cpu_run=1 and ignore rx_ready, including SYNC_BYTE; only rst leaves RUN.
REQ-016 cpu_run SHALL be 1 only in RUN, and imem_we SHALL be 0 outside LOAD.
REQ-017 word_count SHALL saturate at 2^INST_SIZE.
REQ-018 load_err SHALL hold until reset.
REQ-019 tx_start SHALL never be asserted outside ACK.

Reset
REQ-020 While rst=1, state=IDLE and every output SHALL be 0: tx_data, tx_start, imem_we, imem_addr, imem_wdata, cpu_run, word_count, load_err.
REQ-021 Reset asserted mid-LOAD or mid-ACK SHALL discard any partial word and any pending ack, with no write or tx_start after reset asserts.
REQ-022 After rst deasserts, SHALL wait in IDLE for SYNC_BYTE.

Verification
REQ-023 Normal load: send AA, 20 08 00 05, 00 00 00 00 -> writes 0x20080005 at addr 0 and 0x00000000 at addr 1; word_count=2; tx byte 0x55; cpu_run=1.
REQ-024 Noise before sync: send 12, FF, then AA, 00 00 00 00 -> only one write (addr 0, data 0); ack 0x55.
REQ-025 Overflow with INST_SIZE=2: send AA and four nonzero words -> four writes at addr 0..3; load_err=1; ack 0xEE; word_count=4; no write to addr 0 again.
REQ-026 Busy transmitter: hold tx_busy=1 for 50 cycles after the terminator -> tx_start stays 0, then pulses once in the first cycle after tx_busy falls; RUN follows.
REQ-027 Reset mid-word: send AA, 11 22, assert rst -> all outputs 0, state IDLE; then send AA, 00 00 00 00 -> a single write of 0 at addr 0.
REQ-028 Back-to-back bytes: rx_ready every cycle for AA plus 8 bytes -> both words written in order.
